// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch inputs, hazard controls, register-file
// read/writeback ports, IF/ID visibility and ID/EX outputs.
interface decode_stage_if #(
  parameter int word_size     = 32,
  parameter int address_width = 5
);
  logic [word_size-1:0]     instr_f;
  logic [word_size-1:0]     pc_f;
  logic [word_size-1:0]     pcplus4_f;
  logic                     valid_f;

  logic                     stall_d;
  logic                     flush_d;
  logic                     flush_e;

  logic [address_width-1:0] rs1_d;
  logic [address_width-1:0] rs2_d;
  logic [word_size-1:0]     rd_data1;
  logic [word_size-1:0]     rd_data2;

  logic                     we_w;
  logic [address_width-1:0] rd_w;
  logic [word_size-1:0]     result_w;

  logic [word_size-1:0]     instr_d;
  logic [word_size-1:0]     pc_d;
  logic [word_size-1:0]     pcplus4_d;
  logic                     valid_d;

  logic [word_size-1:0]     rd1_e;
  logic [word_size-1:0]     rd2_e;
  logic [word_size-1:0]     imm_e;
  logic [word_size-1:0]     pc_e;
  logic [word_size-1:0]     pcplus4_e;
  logic [address_width-1:0] rs1_e;
  logic [address_width-1:0] rs2_e;
  logic [address_width-1:0] rd_e;
  logic [6:0]               opcode_e;
  logic [2:0]               funct3_e;
  logic                     funct7b5_e;
  logic                     valid_e;

  modport master (
    output instr_f,
    output pc_f,
    output pcplus4_f,
    output valid_f,
    output stall_d,
    output flush_d,
    output flush_e,
    input  rs1_d,
    input  rs2_d,
    output rd_data1,
    output rd_data2,
    output we_w,
    output rd_w,
    output result_w,
    input  instr_d,
    input  pc_d,
    input  pcplus4_d,
    input  valid_d,
    input  rd1_e,
    input  rd2_e,
    input  imm_e,
    input  pc_e,
    input  pcplus4_e,
    input  rs1_e,
    input  rs2_e,
    input  rd_e,
    input  opcode_e,
    input  funct3_e,
    input  funct7b5_e,
    input  valid_e
  );

  modport slave (
    input  instr_f,
    input  pc_f,
    input  pcplus4_f,
    input  valid_f,
    input  stall_d,
    input  flush_d,
    input  flush_e,
    output rs1_d,
    output rs2_d,
    input  rd_data1,
    input  rd_data2,
    input  we_w,
    input  rd_w,
    input  result_w,
    output instr_d,
    output pc_d,
    output pcplus4_d,
    output valid_d,
    output rd1_e,
    output rd2_e,
    output imm_e,
    output pc_e,
    output pcplus4_e,
    output rs1_e,
    output rs2_e,
    output rd_e,
    output opcode_e,
    output funct3_e,
    output funct7b5_e,
    output valid_e
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: IF/ID register, writeback bypass, immediate
// generation and ID/EX register.
module decode_stage #(
  parameter int word_size     = 32,
  parameter int address_width = 5
) (
  input  logic         clk,
  input  logic         reset,
  decode_stage_if.slave bus
);
  localparam logic [word_size-1:0] NOP = word_size'(32'h0000_0013);

  logic [word_size-1:0]     r_instr_d;
  logic [word_size-1:0]     r_pc_d;
  logic [word_size-1:0]     r_pcplus4_d;
  logic                     r_valid_d;

  logic [word_size-1:0]     r_rd1_e;
  logic [word_size-1:0]     r_rd2_e;
  logic [word_size-1:0]     r_imm_e;
  logic [word_size-1:0]     r_pc_e;
  logic [word_size-1:0]     r_pcplus4_e;
  logic [address_width-1:0] r_rs1_e;
  logic [address_width-1:0] r_rs2_e;
  logic [address_width-1:0] r_rd_e;
  logic [6:0]               r_opcode_e;
  logic [2:0]               r_funct3_e;
  logic                     r_funct7b5_e;
  logic                     r_valid_e;

  logic [address_width-1:0] w_rs1;
  logic [address_width-1:0] w_rs2;
  logic [address_width-1:0] w_rd;
  logic [6:0]               w_opcode;
  logic [2:0]               w_funct3;
  logic                     w_funct7b5;
  logic [word_size-1:0]     w_op1;
  logic [word_size-1:0]     w_op2;
  logic [word_size-1:0]     w_imm;
  logic                     w_is_i;
  logic                     w_is_s;
  logic                     w_is_b;
  logic                     w_is_u;
  logic                     w_is_j;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d   <= NOP;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (bus.flush_d) begin
      r_instr_d   <= NOP;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!bus.stall_d) begin
      r_instr_d   <= bus.instr_f;
      r_pc_d      <= bus.pc_f;
      r_pcplus4_d <= bus.pcplus4_f;
      r_valid_d   <= bus.valid_f;
    end
  end

  assign w_rs1      = address_width'(r_instr_d[19:15]);
  assign w_rs2      = address_width'(r_instr_d[24:20]);
  assign w_rd       = address_width'(r_instr_d[11:7]);
  assign w_opcode   = r_instr_d[6:0];
  assign w_funct3   = r_instr_d[14:12];
  assign w_funct7b5 = r_instr_d[30];

  // x0 reads as zero even if writeback targets it or the file returns junk
  always_comb begin
    w_op1 = bus.rd_data1;
    if (w_rs1 == '0) begin
      w_op1 = '0;
    end else if (bus.we_w && (bus.rd_w == w_rs1)) begin
      w_op1 = bus.result_w;
    end
  end

  always_comb begin
    w_op2 = bus.rd_data2;
    if (w_rs2 == '0) begin
      w_op2 = '0;
    end else if (bus.we_w && (bus.rd_w == w_rs2)) begin
      w_op2 = bus.result_w;
    end
  end

  assign w_is_i = (w_opcode == 7'b0000011) ||
                  (w_opcode == 7'b0010011) ||
                  (w_opcode == 7'b1100111);
  assign w_is_s = (w_opcode == 7'b0100011);
  assign w_is_b = (w_opcode == 7'b1100011);
  assign w_is_u = (w_opcode == 7'b0110111) ||
                  (w_opcode == 7'b0010111);
  assign w_is_j = (w_opcode == 7'b1101111);

  always_comb begin
    w_imm = '0;
    unique case (1'b1)
      w_is_i: w_imm = word_size'($signed(
                r_instr_d[31:20]));
      w_is_s: w_imm = word_size'($signed({
                r_instr_d[31:25],
                r_instr_d[11:7]}));
      w_is_b: w_imm = word_size'($signed({
                r_instr_d[31],
                r_instr_d[7],
                r_instr_d[30:25],
                r_instr_d[11:8],
                1'b0}));
      w_is_u: w_imm = word_size'($signed({
                r_instr_d[31:12],
                12'b0}));
      w_is_j: w_imm = word_size'($signed({
                r_instr_d[31],
                r_instr_d[19:12],
                r_instr_d[20],
                r_instr_d[30:21],
                1'b0}));
      default: w_imm = '0;
    endcase
  end

  // stall_d never gates this register; the hazard unit pairs it with flush_e
  always_ff @(posedge clk) begin
    if (reset || bus.flush_e) begin
      r_rd1_e      <= '0;
      r_rd2_e      <= '0;
      r_imm_e      <= '0;
      r_pc_e       <= '0;
      r_pcplus4_e  <= '0;
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
      r_rd_e       <= '0;
      r_opcode_e   <= '0;
      r_funct3_e   <= '0;
      r_funct7b5_e <= 1'b0;
      r_valid_e    <= 1'b0;
    end else begin
      r_rd1_e      <= w_op1;
      r_rd2_e      <= w_op2;
      r_imm_e      <= w_imm;
      r_pc_e       <= r_pc_d;
      r_pcplus4_e  <= r_pcplus4_d;
      r_rs1_e      <= w_rs1;
      r_rs2_e      <= w_rs2;
      r_rd_e       <= w_rd;
      r_opcode_e   <= w_opcode;
      r_funct3_e   <= w_funct3;
      r_funct7b5_e <= w_funct7b5;
      r_valid_e    <= r_valid_d;
    end
  end

  assign bus.rs1_d      = w_rs1;
  assign bus.rs2_d      = w_rs2;
  assign bus.instr_d    = r_instr_d;
  assign bus.pc_d       = r_pc_d;
  assign bus.pcplus4_d  = r_pcplus4_d;
  assign bus.valid_d    = r_valid_d;
  assign bus.rd1_e      = r_rd1_e;
  assign bus.rd2_e      = r_rd2_e;
  assign bus.imm_e      = r_imm_e;
  assign bus.pc_e       = r_pc_e;
  assign bus.pcplus4_e  = r_pcplus4_e;
  assign bus.rs1_e      = r_rs1_e;
  assign bus.rs2_e      = r_rs2_e;
  assign bus.rd_e       = r_rd_e;
  assign bus.opcode_e   = r_opcode_e;
  assign bus.funct3_e   = r_funct3_e;
  assign bus.funct7b5_e = r_funct7b5_e;
  assign bus.valid_e    = r_valid_e;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter: word_size, 32, datapath and instruction width.
REQ-002 SHALL have parameter: address_width, 5, register address width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: instr_f, pc_f, pcplus4_f  in  word_size each  fetch-stage instruction, PC, PC+4.
REQ-006 SHALL have port: valid_f  in  1  fetch output is a real instruction.
REQ-007 SHALL have ports: stall_d  in  1  hold IF/ID; flush_d  in  1  bubble IF/ID; flush_e  in  1  bubble ID/EX.
REQ-008 SHALL have ports: rs1_d, rs2_d  out  address_width  register-file read addresses, combinational from IF/ID instruction bits [19:15], [24:20].
REQ-009 SHALL have ports: rd_data1, rd_data2  in  word_size  register-file read data.
REQ-010 SHALL have ports: we_w  in  1, rd_w  in  address_width, result_w  in  word_size  writeback port, same values driven to the register file.
REQ-011 SHALL have ID/EX outputs: rd1_e, rd2_e, imm_e, pc_e, pcplus4_e (word_size); rs1_e, rs2_e, rd_e (address_width); opcode_e (7); funct3_e (3); funct7b5_e (1); valid_e (1).

Function
REQ-012 SHALL hold an IF/ID register {instr_d, pc_d, pcplus4_d, valid_d}, updated each posedge with priority reset > flush_d > stall_d > load.
REQ-013 SHALL on flush_d load instr_d = 32'h00000013 (NOP), valid_d = 0, pc_d/pcplus4_d = 0.
REQ-014 SHALL on stall_d (no flush_d) hold all IF/ID contents unchanged.
REQ-015 SHALL otherwise load instr_f, pc_f, pcplus4_f, valid_f.
REQ-016 SHALL bypass writeback: operand1 = result_w when we_w && rd_w == rs1_d && rs1_d != 0, else rd_data1; likewise operand2 with rs2_d.
REQ-017 SHALL force operand to 0 when its source address is 0, regardless of rd_data or bypass.
REQ-018 SHALL generate imm by opcode (instr_d[6:0]), sign-extended to word_size:
- I (0000011, 0010011, 1100111): {instr[31:20]}
- S (0100011): {instr[31:25], instr[11:7]}
- B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U (0110111, 0010111): {instr[31:12], 12'b0}
- J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- any other opcode: 0.
REQ-019 SHALL hold an ID/EX register capturing operands, imm, pc_d, pcplus4_d, rs1_d, rs2_d, rd = instr_d[11:7], opcode, funct3 = instr_d[14:12], funct7b5 = instr_d[30], valid_d each posedge; priority reset > flush_e > load.
REQ-020 SHALL on flush_e clear every ID/EX field to 0 (bubble: valid_e = 0, rd_e = 0, opcode_e = 0).
REQ-021 SHALL NOT gate ID/EX load with stall_d; the hazard unit asserts flush_e alongside stall_d.
REQ-022 SHALL have latency: instruction presented at fetch on edge N appears on ID/EX outputs after edge N+1 (two registers, zero added bubbles).
REQ-023 SHALL, with stall_d and flush_d both high, apply flush_d.
REQ-024 SHALL, with flush_d and flush_e both high, bubble both registers on the same edge.
REQ-025 SHALL give we_w with rd_w = 0 no effect on operands.

Reset
REQ-026 SHALL on reset load IF/ID with instr_d = 32'h00000013, valid_d = 0, pc_d = pcplus4_d = 0.
REQ-027 SHALL on reset clear every ID/EX output to 0, including valid_e.
REQ-028 SHALL let reset asserted mid-stall or mid-flush override both; the first non-reset edge loads normally.

Verification
REQ-029 SHALL cover: addi x5,x0,-1 (32'hFFF00293), pc_f = 0x100, valid_f = 1, two edges -> imm_e = 0xFFFFFFFF, rd_e = 5, rs1_e = 0, rd1_e = 0, pc_e = 0x100, valid_e = 1.
REQ-030 SHALL cover: rs1_d = 3, rd_data1 = 0x11, we_w = 1, rd_w = 3, result_w = 0xAB -> rd1_e = 0xAB after edge; with rd_w = 4 -> rd1_e = 0x11.
REQ-031 SHALL cover: stall_d high for 3 edges with changing instr_f -> instr_d, pc_d unchanged; flush_e asserted same edges -> valid_e = 0, rd_e = 0.
REQ-032 SHALL cover: stall_d = flush_d = 1 -> instr_d = 0x00000013, valid_d = 0.
REQ-033 SHALL cover: beq with offset -4 (32'hFE000EE3) -> imm_e = 0xFFFFFFFC; jal with offset +2048 (32'h0010006F) -> imm_e = 0x00000800.
REQ-034 SHALL cover: reset during a stall with valid contents -> all ID/EX outputs 0, instr_d = NOP, next edge loads instr_f.
